// File: rtl/tank_round_sequencer.sv
// Round and score controller for the two-player tank game: gates switches, keeps
// score and times the attract/serve/play/hit/game-over flow in video frames.
module tank_round_sequencer #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned HIT_FRAMES   = 90,
  parameter int unsigned OVER_FRAMES  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys,
  input  logic       vsync,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [3:0] switches_p1,
  output logic [3:0] switches_p2,
  output logic       playfield_reset,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StAttract  = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StHit      = 3'd3,
    StGameover = 3'd4
  } state_e;

  localparam logic [3:0] Win       = 4'(WIN_SCORE);
  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] HitLast   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] OverLast  = 8'(OVER_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vsync_q;
  logic [7:0] keys_q;
  logic [3:0] sw_p1_d, sw_p2_d, score_p1_d, score_p2_d;
  logic       pf_reset_d;
  logic [1:0] winner_d;
  logic       tick, start, game_won;

  assign tick     = vsync & ~vsync_q;
  assign start    = (keys_q == 8'h00) & (keys != 8'h00);
  assign game_won = (score_p1 == Win) | (score_p2 == Win);
  assign state    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StAttract;
      frame_cnt_q     <= 8'h00;
      vsync_q         <= 1'b0;
      keys_q          <= 8'hFF;
      switches_p1     <= 4'h0;
      switches_p2     <= 4'h0;
      playfield_reset <= 1'b0;
      score_p1        <= 4'h0;
      score_p2        <= 4'h0;
      winner          <= 2'b00;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      vsync_q         <= vsync;
      keys_q          <= keys;
      switches_p1     <= sw_p1_d;
      switches_p2     <= sw_p2_d;
      playfield_reset <= pf_reset_d;
      score_p1        <= score_p1_d;
      score_p2        <= score_p2_d;
      winner          <= winner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StAttract:  if (start) state_d = StServe;
      StServe:    if (tick && frame_cnt_q == ServeLast) state_d = StPlay;
      StPlay:     if (hit_p1 || hit_p2) state_d = StHit;
      StHit: begin
        if (tick && frame_cnt_q == HitLast) state_d = game_won ? StGameover : StServe;
      end
      StGameover: if (tick && frame_cnt_q == OverLast) state_d = StAttract;
      default:    state_d = StAttract;
    endcase
  end

  always_comb begin
    score_p1_d = score_p1;
    score_p2_d = score_p2;
    winner_d   = winner;
    sw_p1_d    = 4'h0;
    sw_p2_d    = 4'h0;
    pf_reset_d = (state_d == StServe) && (state_q != StServe);
    // A tick in the transition cycle belongs to the old state only.
    if (state_d != state_q) begin
      frame_cnt_d = 8'h00;
    end else if (tick) begin
      frame_cnt_d = frame_cnt_q + 8'h01;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (state_q == StAttract && start) begin
      score_p1_d = 4'h0;
      score_p2_d = 4'h0;
      winner_d   = 2'b00;
    end
    if (state_q == StPlay) begin
      if (hit_p1 && score_p2 < Win) score_p2_d = score_p2 + 4'h1;
      if (hit_p2 && score_p1 < Win) score_p1_d = score_p1 + 4'h1;
    end
    if (state_q == StHit && state_d == StGameover) begin
      winner_d = {score_p2 == Win, score_p1 == Win};
    end
    if (state_d == StPlay) begin
      sw_p1_d = keys[3:0];
      sw_p2_d = keys[7:4];
    end
  end

endmodule

// File: tb/tb_tank_round_sequencer.sv
// Bench for tank_round_sequencer: directed vector table, hand-written game sequences and
// randomized play, all checked against a frame-countdown reference model.
module tb_tank_round_sequencer;

  localparam int W  = 4;
  localparam int SF = 3;
  localparam int HF = 2;
  localparam int OF = 3;

  localparam int PA = 0, PS = 1, PP = 2, PH = 3, PG = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keys;
  logic       vsync, hit_p1, hit_p2;
  logic [3:0] switches_p1, switches_p2, score_p1, score_p2;
  logic       playfield_reset;
  logic [1:0] winner;
  logic [2:0] state;

  tank_round_sequencer #(
    .WIN_SCORE   (W),
    .SERVE_FRAMES(SF),
    .HIT_FRAMES  (HF),
    .OVER_FRAMES (OF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .keys           (keys),
    .vsync          (vsync),
    .hit_p1         (hit_p1),
    .hit_p2         (hit_p2),
    .switches_p1    (switches_p1),
    .switches_p2    (switches_p2),
    .playfield_reset(playfield_reset),
    .score_p1       (score_p1),
    .score_p2       (score_p2),
    .winner         (winner),
    .state          (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase plus frames still to spend in it.
  int         m_ph, m_left, m_s1, m_s2;
  logic [1:0] m_win;
  logic [3:0] m_sw1, m_sw2;
  logic       m_pf, m_vs;
  logic [7:0] m_kq;
  logic [7:0] kc;

  typedef struct {
    logic [7:0] k;
    logic       v, h1, h2;
    logic [2:0] st;
    logic       pf;
    logic [3:0] sw1, sw2, s1, s2;
    logic [1:0] win;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {10'd0, state, playfield_reset, switches_p1, switches_p2, score_p1, score_p2, winner};
  endfunction

  function automatic int frames_for(input int ph);
    case (ph)
      PS:      return SF;
      PH:      return HF;
      PG:      return OF;
      default: return 0;
    endcase
  endfunction

  function automatic int sat_inc(input int s);
    return (s >= W) ? W : s + 1;
  endfunction

  task automatic model_reset();
    m_ph = PA; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 2'b00;
    m_sw1 = 4'h0; m_sw2 = 4'h0; m_pf = 1'b0; m_vs = 1'b0; m_kq = 8'hFF;
  endtask

  task automatic model_step(input logic [7:0] k, input logic v, input logic h1,
                            input logic h2);
    bit tick, start;
    int nph;
    tick  = v && !m_vs;
    start = (m_kq == 8'h00) && (k != 8'h00);
    nph   = m_ph;
    case (m_ph)
      PA: if (start) begin nph = PS; m_s1 = 0; m_s2 = 0; m_win = 2'b00; end
      PS: if (tick) begin m_left--; if (m_left == 0) nph = PP; end
      PP: begin
        if (h1) m_s2 = sat_inc(m_s2);
        if (h2) m_s1 = sat_inc(m_s1);
        if (h1 || h2) nph = PH;
      end
      PH: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == W || m_s2 == W) begin
            nph   = PG;
            m_win = {m_s2 == W, m_s1 == W};
          end else begin
            nph = PS;
          end
        end
      end
      default: if (tick) begin m_left--; if (m_left == 0) nph = PA; end
    endcase
    m_pf = (nph == PS) && (m_ph != PS);
    if (nph != m_ph) m_left = frames_for(nph);
    m_ph  = nph;
    m_sw1 = (nph == PP) ? k[3:0] : 4'h0;
    m_sw2 = (nph == PP) ? k[7:4] : 4'h0;
    m_vs  = v;
    m_kq  = k;
  endtask

  function automatic logic [31:0] model_vec();
    return {10'd0, 3'(m_ph), m_pf, m_sw1, m_sw2, 4'(m_s1), 4'(m_s2), m_win};
  endfunction

  task automatic step(input logic [7:0] k, input logic v, input logic h1, input logic h2);
    @(negedge clk);
    keys = k; vsync = v; hit_p1 = h1; hit_p2 = h2;
    kc = k;
    @(posedge clk);
    model_step(k, v, h1, h2);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(kc, 1'b1, 1'b0, 1'b0);
      step(kc, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[3]  = '{8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[4]  = '{8'h10, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[5]  = '{8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[6]  = '{8'h10, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[7]  = '{8'h03, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[8]  = '{8'h03, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 4'h3, 4'h0, 4'd0, 4'd0, 2'b00};
    vecs[9]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 4'hA, 4'h5, 4'd0, 4'd0, 2'b00};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 4'h0, 4'h0, 4'd0, 4'd1, 2'b00};
    vecs[11] = '{8'h5A, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 4'h0, 4'h0, 4'd0, 4'd1, 2'b00};
    vecs[12] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'h0, 4'h0, 4'd0, 4'd1, 2'b00};
    vecs[13] = '{8'h5A, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 4'h0, 4'h0, 4'd0, 4'd1, 2'b00};
    vecs[14] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0, 4'h0, 4'd0, 4'd1, 2'b00};

    reset = 1'b0; keys = 8'h01; vsync = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0; kc = 8'h01;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_values", dut_vec(), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Directed table: start from held keys, serve timing, single hit, return to serve.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].k, vecs[i].v, vecs[i].h1, vecs[i].h2);
      check($sformatf("vec%0d", i), dut_vec(),
            {10'd0, vecs[i].st, vecs[i].pf, vecs[i].sw1, vecs[i].sw2, vecs[i].s1, vecs[i].s2,
             vecs[i].win});
    end

    // Hits during SERVE and HIT are ignored; build up to 3/1 in PLAY.
    step(kc, 1'b0, 1'b1, 1'b1);
    check("serve_hit_ignored", {score_p1, score_p2}, {4'd0, 4'd1});
    for (int i = 0; i < 3; i++) begin
      frames(SF);
      step(kc, 1'b0, 1'b0, 1'b1);
      step(kc, 1'b0, 1'b1, 1'b0);
      frames(HF);
    end
    frames(SF);
    check("play_3_1", {state, score_p1, score_p2}, {3'd2, 4'd3, 4'd1});

    // Asynchronous reset mid-game: outputs clear without a clock edge.
    #2 reset = 1'b0;
    #1 check("async_reset", dut_vec(), 32'd0);
    model_reset();
    keys = 8'h00; kc = 8'h00;
    @(posedge clk);
    #2 reset = 1'b1;
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0, 1'b0);
    check("restart_serve", {state, playfield_reset}, {3'd1, 1'b1});

    // Simultaneous hits up to 3/3, then a double hit at match point.
    for (int i = 0; i < 3; i++) begin
      frames(SF);
      step(kc, 1'b0, 1'b1, 1'b1);
      frames(HF);
    end
    frames(SF);
    step(kc, 1'b0, 1'b1, 1'b1);
    check("double_hit", {state, score_p1, score_p2}, {3'd3, 4'd4, 4'd4});
    frames(HF);
    check("gameover", {state, winner}, {3'd4, 2'b11});
    step(8'h00, 1'b0, 1'b1, 1'b1);
    step(8'h11, 1'b0, 1'b0, 1'b1);
    check("gameover_ignores", {state, score_p1, score_p2}, {3'd4, 4'd4, 4'd4});
    frames(OF);
    check("attract_hold", {state, score_p1, score_p2, winner}, {3'd0, 4'd4, 4'd4, 2'b11});

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      step(k, 1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      if ((i % 100) == 0) check("saturate", 32'(score_p1 > W || score_p2 > W), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
